binary_to_bcd: RTL and testbench

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

---
 rtl/binary_to_bcd.sv | 115 +++++++++++
 tb/tb_binary_to_bcd.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd.sv
// binary_to_bcd: sequential 14-bit binary to 4-digit packed BCD converter.
// Uses shift-add-3 (double dabble) with one iteration per clock over a
// 5-digit scratch register; the fifth digit flags values above 9999.
// A conversion takes 15 edges from the start edge to the done edge, and the
// done edge also samples start so back-to-back conversions run every 15 cycles.
module binary_to_bcd #(
    parameter int SATURATE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] in,
    output logic [15:0] out,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'd14;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [13:0] bin;
    logic [19:0] scratch;
    logic [19:0] adjusted;
    logic        finish;
    logic        capture;
    logic        busy_next;
    logic        done_next;

    // Add 3 to every BCD digit that is 5 or more, so the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [19:0] add3(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int d = 0; d < 5; d++) begin
            if (r[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Overflow handling: clamp to 9999 or keep the low four digits.
    function automatic logic [15:0] clamp(input logic [19:0] s);
        if ((s[19:16] != 4'd0) && (SATURATE != 0)) begin
            return 16'h9999;
        end
        return s[15:0];
    endfunction

    assign adjusted = add3(scratch);
    assign finish   = (state == SHIFT) && (count == LAST_ITER);
    assign capture  = start && ((state == IDLE) || finish);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start on the completing edge re-enters SHIFT directly.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (finish && !start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy is low in the done cycle even when a new run begins.
    always_comb begin
        busy_next = (state_next == SHIFT) && !finish;
        done_next = finish;
    end

    // Datapath and registered outputs: capture, iterate, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 4'd0;
            bin     <= 14'd0;
            scratch <= 20'd0;
            out     <= 16'h0000;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            if (finish) begin
                out <= clamp(scratch);
                ovf <= (scratch[19:16] != 4'd0);
            end
            if (capture) begin
                bin     <= in;
                scratch <= 20'd0;
                count   <= 4'd0;
            end else if ((state == SHIFT) && !finish) begin
                {scratch, bin} <= {adjusted[18:0], bin, 1'b0};
                count          <= count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd: scoreboard bench for binary_to_bcd, clamping and wrapping
// variants side by side on the same stimulus.
module tb_binary_to_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] in;
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] out_w;
    logic        busy_w;
    logic        done_w;
    logic        ovf_w;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int v;
        int due;
    } ent_t;

    ent_t q[$];
    logic act      = 1'b0;
    int   end_cyc  = 0;
    logic exp_busy = 1'b0;

    logic [15:0] last_out   = 16'h0000;
    logic        last_ovf   = 1'b0;
    logic [15:0] last_out_w = 16'h0000;
    logic        last_ovf_w = 1'b0;

    binary_to_bcd #(.SATURATE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in(in),
        .out(out), .busy(busy), .done(done), .ovf(ovf)
    );

    binary_to_bcd #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .in(in),
        .out(out_w), .busy(busy_w), .done(done_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act_v, exp_v, cyc);
        end
    endtask

    // Reference: {ovf, packed BCD} for value v and a given overflow mode.
    function automatic logic [16:0] ref_bcd(input int v, input int sat);
        int          low;
        logic [15:0] b;
        low = v % 10000;
        b = {4'(low / 1000), 4'((low / 100) % 10), 4'((low / 10) % 10), 4'(low % 10)};
        if (v > 9999 && sat != 0) b = 16'h9999;
        return {(v > 9999), b};
    endfunction

    // Acceptance model: push expected completions when the DUT should take start.
    always @(posedge clk) begin
        logic fin;
        cyc++;
        fin = 1'b0;
        if (rst) begin
            q.delete();
            act      = 1'b0;
            exp_busy = 1'b0;
        end else begin
            if (act && cyc == end_cyc) begin
                fin = 1'b1;
                act = 1'b0;
            end
            if (start && !act) begin
                q.push_back('{v: int'(in), due: cyc + 15});
                act     = 1'b1;
                end_cyc = cyc + 15;
            end
            exp_busy = act && !fin;
        end
    end

    // Output monitor: compare against the scoreboard away from the active edge.
    always @(negedge clk) begin
        logic        exp_done;
        logic [16:0] r;
        ent_t        e;
        if (rst) begin
            last_out   = 16'h0000;
            last_ovf   = 1'b0;
            last_out_w = 16'h0000;
            last_ovf_w = 1'b0;
        end else begin
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            if (exp_done) begin
                e = q.pop_front();
                r = ref_bcd(e.v, 1);
                last_out = r[15:0];
                last_ovf = r[16];
                r = ref_bcd(e.v, 0);
                last_out_w = r[15:0];
                last_ovf_w = r[16];
                for (int d = 0; d < 4; d++) begin
                    chk("digit_range", 32'(out[4*d +: 4] > 4'd9), 32'd0);
                end
            end
            chk("done", 32'(done), 32'(exp_done));
            chk("done_wrap", 32'(done_w), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("busy_wrap", 32'(busy_w), 32'(exp_busy));
            chk("out", 32'(out), 32'(last_out));
            chk("ovf", 32'(ovf), 32'(last_ovf));
            chk("out_wrap", 32'(out_w), 32'(last_out_w));
            chk("ovf_wrap", 32'(ovf_w), 32'(last_ovf_w));
        end
    end

    // One conversion, leaving start low until the edge that finishes it.
    task automatic btb(input int v);
        in    = 14'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in    = 14'd0;
        idle(2);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;

        // zero input
        btb(0);
        idle(3);

        // back-to-back 1234 then 9999
        btb(1234);
        btb(9999);
        idle(3);

        // overflow in both modes
        btb(12345);
        idle(3);

        // start held high for 20 cycles
        in    = 14'd42;
        start = 1'b1;
        idle(20);
        start = 1'b0;
        idle(20);

        // reset mid-conversion, then a clean rerun
        in    = 14'd5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(6);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("abort_out", 32'(out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ovf", 32'(ovf), 32'h0);
        btb(5000);
        idle(3);
        chk("rerun_out", 32'(out), 32'h5000);

        // sweep of the decimal range plus overflow corners
        for (int v = 0; v < 10000; v += 4) btb(v);
        btb(9999);
        btb(10000);
        btb(16383);
        for (int i = 0; i < 8; i++) btb(int'($urandom_range(16383, 0)));
        idle(20);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
